lcd_num_texto: RTL

//  Parametrised on-screen numeric readout for the LCD pipeline. Drives an external synchronous character ROM and outputs per-pixel letra_ON.

---
 rtl/lcd_num_texto.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_num_texto.sv
// Numeric text overlay for the LCD pipeline: sequential binary->BCD conversion
// committed once per request, rendered through an external synchronous char ROM.
module lcd_num_texto #(
    parameter int          COL_MAX    = 800,
    parameter int          FILA_MAX   = 480,
    parameter int          VALUE_W    = 14,
    parameter int          N_DIGITS   = 5,
    parameter int          SUF_LEN    = 3,
    parameter logic [23:0] SUFFIX     = {6'o00, 6'o40, 6'o10, 6'o32},
    parameter logic [5:0]  CHAR_0     = 6'o60,
    parameter logic [5:0]  CHAR_BLANK = 6'o40,
    parameter logic [5:0]  CHAR_DASH  = 6'o55,
    parameter int          POT_TAM    = 2,
    parameter int          X0         = 64,
    parameter int          Y0         = 96,
    parameter int          JUSTIFY    = 0
) (
    input  logic                         NCLK,
    input  logic                         RESET,
    input  logic                         new_frame,
    input  logic [VALUE_W-1:0]           value,
    input  logic [$clog2(COL_MAX-1)-1:0] columna,
    input  logic [$clog2(FILA_MAX-1)-1:0] fila,
    output logic [8:0]                   rom_addr,
    input  logic [7:0]                   rom_q,
    output logic                         letra_ON,
    output logic                         busy,
    output logic                         overflow
);

    function automatic int f_ndig(input int w);
        longint v;
        int     n;
        v = (longint'(1) << w) - 1;
        n = 1;
        while (v > 9) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    localparam int N_BCD  = f_ndig(VALUE_W);
    localparam int N_INT  = (N_BCD > N_DIGITS) ? N_BCD : N_DIGITS;
    localparam int N_SLOT = N_DIGITS + SUF_LEN;
    localparam int CNT_W  = $clog2(VALUE_W + 1);

    function automatic logic f_ovf(input logic [4*N_INT-1:0] bcd);
        logic o;
        o = 1'b0;
        for (int i = N_DIGITS; i < N_INT; i++)
            if (bcd[4*i +: 4] != 4'd0) o = 1'b1;
        return o;
    endfunction

    // Slot 0 is the leftmost character on screen.
    function automatic logic [N_SLOT-1:0][5:0] f_layout(input logic [4*N_INT-1:0] bcd);
        logic [N_SLOT-1:0][5:0] base;
        logic [N_SLOT-1:0][5:0] res;
        logic                   ovf;
        int                     nv;
        int                     shift;
        ovf = f_ovf(bcd);
        nv  = 1;
        for (int i = 0; i < N_DIGITS; i++)
            if (bcd[4*i +: 4] != 4'd0) nv = i + 1;
        base = '0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (ovf)
                base[j] = CHAR_DASH;
            else if ((N_DIGITS - 1 - j) >= nv)
                base[j] = CHAR_BLANK;
            else
                base[j] = CHAR_0 + 6'(bcd[4*(N_DIGITS-1-j) +: 4]);
        end
        for (int k = 0; k < SUF_LEN; k++)
            base[N_DIGITS+k] = SUFFIX[6*(SUF_LEN-1-k) +: 6];
        shift = (JUSTIFY != 0 && !ovf) ? (N_DIGITS - nv) : 0;
        for (int j = 0; j < N_SLOT; j++) begin
            res[j] = CHAR_BLANK;
            for (int m = 0; m < N_SLOT; m++)
                if (m == j + shift) res[j] = base[m];
        end
        return res;
    endfunction

    // state    | meaning
    // S_IDLE   | waiting for new_frame; value latched on acceptance
    // S_LOAD   | arm the step counter
    // S_SHIFT  | one add-3/shift step per clock, VALUE_W steps
    // S_COMMIT | copy digits and overflow to display regs in one edge
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} state_t;

    state_t                       r_state;
    logic                         r_busy;
    logic [VALUE_W-1:0]           r_bin;
    logic [4*N_INT-1:0]           r_bcd;
    logic [CNT_W-1:0]             r_cnt;
    logic [N_SLOT-1:0][5:0]       r_disp;
    logic                         r_ovf;
    logic [4*N_INT-1:0]           w_bcd_adj;
    logic [4*N_INT+VALUE_W-1:0]   w_next;

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < N_INT; i++)
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        w_next = {w_bcd_adj, r_bin} << 1;
    end

    always_ff @(posedge NCLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_disp  <= f_layout('0);
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (new_frame) begin
                    r_bin   <= value;
                    r_bcd   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_cnt   <= CNT_W'(VALUE_W - 1);
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    {r_bcd, r_bin} <= w_next;
                    if (r_cnt == '0) r_state <= S_COMMIT;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                S_COMMIT: begin
                    r_disp  <= f_layout(r_bcd);
                    r_ovf   <= f_ovf(r_bcd);
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pixel path; underflow of the subtractions is rejected by the >= compares.
    logic [31:0] w_dx, w_px, w_slot, w_dy, w_py;
    logic        w_in_box;
    logic [5:0]  w_char;

    always_comb begin
        w_dx     = 32'(columna) - 32'(X0);
        w_px     = w_dx >> POT_TAM;
        w_slot   = w_px >> 3;
        w_dy     = 32'(fila) - 32'(Y0);
        w_py     = w_dy >> POT_TAM;
        w_in_box = (32'(columna) >= 32'(X0)) && (w_slot < 32'(N_SLOT)) &&
                   (32'(fila) >= 32'(Y0)) && ((w_py >> 3) == 32'd0);
        w_char   = CHAR_BLANK;
        for (int s = 0; s < N_SLOT; s++)
            if (w_slot == 32'(s)) w_char = r_disp[s];
    end

    logic [8:0] r_addr;
    logic       r_in_d1, r_in_d2, r_letra;
    logic [2:0] r_bit_d1, r_bit_d2;

    always_ff @(posedge NCLK or posedge RESET) begin
        if (RESET) begin
            r_addr   <= '0;
            r_in_d1  <= 1'b0;
            r_in_d2  <= 1'b0;
            r_bit_d1 <= '0;
            r_bit_d2 <= '0;
            r_letra  <= 1'b0;
        end else begin
            r_addr   <= w_in_box ? {w_char, w_py[2:0]} : 9'd0;
            r_in_d1  <= w_in_box;
            r_bit_d1 <= w_px[2:0];
            r_in_d2  <= r_in_d1;
            r_bit_d2 <= r_bit_d1;
            r_letra  <= r_in_d2 & rom_q[3'd7 - r_bit_d2];
        end
    end

    assign rom_addr = r_addr;
    assign letra_ON = r_letra;
    assign busy     = r_busy;
    assign overflow = r_ovf;

endmodule
